data_memory: RTL and testbench
==============================

// Module: data_memory
//
// PURPOSE
// - Word-organised data memory for the MEM stage of the MIPS pipeline.
// - Serves lw/sw traffic: synchronous write on the rising clock edge,
//   combinational read gated by MemRead.
// - Byte address in; word select from Address[ADDR_BITS+1:2]. Byte offset bits [1:0] are ignored.
// - Contents cleared by reset so simulation and hardware start from a known state.
//
// PARAMETERS
// - DATA_WIDTH  32    width of a memory word and of the data ports
// - DEPTH       1024  number of words
// - ADDR_BITS   10    word-index width, = clog2(DEPTH)
//
// PORTS
// - Clk        in   1   single clock; all writes occur on its rising edge
// - Rst        in   1   reset, asynchronous, active-low; clears all words
// - Address    in   32  byte address; word index = Address[ADDR_BITS+1:2]
// - WriteData  in   32  data stored when MemWrite=1
// - MemWrite   in   1   write enable, sampled at the rising edge of Clk
// - MemRead    in   1   read enable; when 0, ReadData is forced to 0
// - ReadData   out  32  word read from mem[index] while MemRead=1, otherwise 0
//
// BEHAVIOUR
// - Reset: Rst=0 immediately zeroes every word, independent of Clk.
//   - While Rst=0, writes are blocked and ReadData=0.
//   - Releasing reset mid-cycle gives no spurious write; first write is on the next qualified rising edge.
// - Write: at a rising edge of Clk with Rst=1 and MemWrite=1, mem[index] <= WriteData.
//   - One write per cycle; no byte enables; full-word write only.
// - Read: combinational, zero-cycle latency.
//   - ReadData = MemRead ? mem[index] : 0.
//   - ReadData follows Address and contents changes within the same cycle.
// - MemRead and MemWrite both 1: before the edge, ReadData shows the old word.
//   After the edge it shows WriteData (write-first as seen from the next cycle). This is legal, not an error.
// - Neither enable asserted: no state change, ReadData=0.
// - Address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo DEPTH*4 bytes.
//   Example: 0x0000_1000 aliases word 0 when DEPTH=1024.
// - Unaligned addresses (e.g. 3, 7) use the containing word. No trap or flag is raised.
// - X or Z on MemWrite must not corrupt memory in simulation: write only when MemWrite === 1.
//
// STRUCTURE
// - Shared package (mips_pkg) holds:
//   - DATA_WIDTH and the default DEPTH/ADDR_BITS constants
//   - a word_t typedef, reused by the register file and instruction memory
// - Storage: a reg array [0:DEPTH-1] of word_t, clear-on-reset in one always block sensitive to posedge Clk / negedge Rst.
// - Read path: a separate continuous assign.
// - Optional sub-module: mem_word_index.
//   - Strips the byte offset and wraps the address.
//   - Is shared with instruction_memory.
//   - Otherwise the design is flat.
//
// TESTING
// - Reset: hold Rst=0 and then release it.
//   - Required: MemRead=1 returns 0 at Address 0, 4 and 4092.
//   - Required: MemWrite pulses issued while Rst=0 have no effect.
// - Write then read:
//   - Write 0x3 at Address 3, then read with MemRead=1, MemWrite=0 -> ReadData=0x3.
//   - Write 0x5 at Address 7 -> readback 0x5.
//   - Write 0x7 at Address 8 -> readback 0x7; word 0 still holds 0x3.
// - Read gating: the word at Address 8 holds 0x7 and MemRead=0 -> ReadData=0.
//   Raising MemRead in the same cycle -> 0x7 with no clock edge.
// - Simultaneous enables:
//   - Word 16 holds 0xAAAA_AAAA; write 0x5555_5555 to it with MemRead=1.
//   - Required: ReadData=0xAAAA_AAAA before the edge and 0x5555_5555 after it.
// - Aliasing: write 0xDEAD_BEEF at Address 0x1000 -> read at Address 0x0 returns 0xDEAD_BEEF.
// - Async reset mid-run: drop Rst between clock edges after the writes above.
//   - Required: ReadData goes to 0 at once.
//   - Required: after release, all previously written words read 0.

Source files
------------

// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module : data_memory_pkg
//  Brief  : Shared constants and word type for the MIPS memory blocks
//           (data memory, instruction memory, register file).
//  Rev    : 1.0  initial release
// ============================================================================
//  Contents
//    C_DATA_WIDTH  width of one machine word
//    C_DEPTH       default number of words in a data memory
//    C_ADDR_BITS   default word-index width, clog2(C_DEPTH)
//    word_t        one machine word
// ============================================================================
package data_memory_pkg;

  localparam int C_DATA_WIDTH = 32;
  localparam int C_DEPTH      = 1024;
  localparam int C_ADDR_BITS  = 10;

  typedef logic [C_DATA_WIDTH-1:0] word_t;

endpackage : data_memory_pkg
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
//  Module : data_memory_if
//  Brief  : MEM-stage load/store bus between the pipeline and data memory.
//  Rev    : 1.0  initial release
// ============================================================================
//  Signals
//    Address    32          byte address
//    WriteData  DATA_WIDTH  store data
//    MemWrite   1           store enable
//    MemRead    1           load enable
//    ReadData   DATA_WIDTH  load data (0 when MemRead=0)
//  Modports
//    master  pipeline side, drives address/data/enables
//    slave   memory side, drives ReadData
// ============================================================================
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH
);

  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output Address,
    output WriteData,
    output MemWrite,
    output MemRead,
    input  ReadData
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemWrite,
    input  MemRead,
    output ReadData
  );

endinterface : data_memory_if
`default_nettype wire

// File: rtl/data_memory_mem_word_index.sv
`default_nettype none
// ============================================================================
//  Module : mem_word_index
//  Brief  : Byte address to word index. Drops the byte offset and the bits
//           above the array, so addresses wrap modulo DEPTH*4 bytes and
//           unaligned addresses select their containing word.
//  Rev    : 1.0  initial release
// ============================================================================
//  Ports
//    i_addr   in   32         byte address
//    o_index  out  ADDR_BITS  word index = i_addr[ADDR_BITS+1:2]
// ============================================================================
module mem_word_index #(
  parameter int ADDR_BITS = 10
) (
  input  wire logic [31:0]          i_addr,
  output logic      [ADDR_BITS-1:0] o_index
);

  // Discarded address bits, kept visible so the drop is clearly deliberate.
  logic w_unused_bits;

  assign o_index       = i_addr[ADDR_BITS+1:2];
  assign w_unused_bits = ^{i_addr[31:ADDR_BITS+2], i_addr[1:0]};

endmodule : mem_word_index
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module : data_memory
//  Brief  : Word-organised data memory for the MIPS MEM stage. Synchronous
//           full-word writes, combinational reads gated by MemRead, all
//           contents cleared by an asynchronous active-low reset.
//  Rev    : 1.0  initial release
// ============================================================================
//  Ports
//    Clk   in     1   clock, writes occur on its rising edge
//    Rst   in     1   asynchronous active-low reset, clears every word
//    bus   slave  -   load/store bus (Address, WriteData, MemWrite,
//                     MemRead in; ReadData out)
// ============================================================================
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int DEPTH      = C_DEPTH,
  parameter int ADDR_BITS  = C_ADDR_BITS
) (
  input wire logic          Clk,
  input wire logic          Rst,
  data_memory_if.slave      bus
);

  logic [ADDR_BITS-1:0]  w_index;
  logic                  w_we;
  logic                  w_re;
  logic [DATA_WIDTH-1:0] w_mem [0:DEPTH-1];

  mem_word_index #(
    .ADDR_BITS (ADDR_BITS)
  ) u_word_index (
    .i_addr  (bus.Address),
    .o_index (w_index)
  );

  // Case-equality so an unknown enable never writes in simulation.
  assign w_we = Rst && (bus.MemWrite === 1'b1);
  assign w_re = Rst && (bus.MemRead  === 1'b1);

  // One register per word: each word owns its clear and its write decode,
  // which keeps every storage element single-driven.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    localparam logic [ADDR_BITS-1:0] c_idx = ADDR_BITS'(gi);

    logic [DATA_WIDTH-1:0] r_word;

    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
        r_word <= '0;
      end else if (w_we && (w_index == c_idx)) begin
        r_word <= bus.WriteData;
      end
    end

    assign w_mem[gi] = r_word;
  end

  // Zero-latency read; with both enables high this shows the old word until
  // the edge, then the newly written word.
  assign bus.ReadData = w_re ? w_mem[w_index] : '0;

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module : tb_data_memory
//  Brief  : Self-checking bench for data_memory: directed vector table,
//           hand-written reset/gating sequences, random traffic against a
//           word-array reference model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_data_memory;

  logic Clk;
  logic Rst;

  data_memory_if bus ();

  data_memory u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;   // ReadData expected before the following edge
    string       name;
  } vec_t;

  int n_vec;
  int n_err;

  logic [31:0] mdl [0:1023];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: ReadData=%08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = w;
    bus.MemRead   = r;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  vec_t vecs [$];

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs.push_back('{32'd0,        32'h0,         1'b0, 1'b1, 32'h0,         "post_reset_a0"});
    vecs.push_back('{32'd4,        32'h0,         1'b0, 1'b1, 32'h0,         "post_reset_a4"});
    vecs.push_back('{32'd4092,     32'h0,         1'b0, 1'b1, 32'h0,         "post_reset_a4092"});
    vecs.push_back('{32'd3,        32'h3,         1'b1, 1'b0, 32'h0,         "wr_a3_gated"});
    vecs.push_back('{32'd3,        32'h0,         1'b0, 1'b1, 32'h3,         "rd_a3"});
    vecs.push_back('{32'd7,        32'h5,         1'b1, 1'b0, 32'h0,         "wr_a7_gated"});
    vecs.push_back('{32'd7,        32'h0,         1'b0, 1'b1, 32'h5,         "rd_a7"});
    vecs.push_back('{32'd8,        32'h7,         1'b1, 1'b0, 32'h0,         "wr_a8_gated"});
    vecs.push_back('{32'd8,        32'h0,         1'b0, 1'b1, 32'h7,         "rd_a8"});
    vecs.push_back('{32'd0,        32'h0,         1'b0, 1'b1, 32'h3,         "rd_a0_kept"});
    vecs.push_back('{32'd8,        32'h0,         1'b0, 1'b0, 32'h0,         "rd_a8_gated"});
    vecs.push_back('{32'd64,       32'hAAAA_AAAA, 1'b1, 1'b0, 32'h0,         "wr_w16_a"});
    vecs.push_back('{32'd64,       32'h5555_5555, 1'b1, 1'b1, 32'hAAAA_AAAA, "both_en_before"});
    vecs.push_back('{32'd64,       32'h0,         1'b0, 1'b1, 32'h5555_5555, "both_en_after"});
    vecs.push_back('{32'h0000_1000,32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         "wr_alias_1000"});
    vecs.push_back('{32'd0,        32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "rd_alias_a0"});
    vecs.push_back('{32'h0000_1002,32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "rd_alias_unal"});
    vecs.push_back('{32'd66,       32'h0,         1'b0, 1'b1, 32'h5555_5555, "rd_w16_unal"});

    // ---------------- reset held, writes must be blocked ----------------
    Rst = 1'b0;
    drive(32'd0, 32'h1234_5678, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge Clk);
      bus.Address   = bus.Address + 32'd4;
      bus.WriteData = bus.WriteData + 32'd1;
      #1 check("in_reset_rd", bus.ReadData, 32'h0);
    end
    // Release between edges with no write pending.
    @(negedge Clk);
    drive(32'd0, 32'h0, 1'b0, 1'b1);
    #2 Rst = 1'b1;

    // ---------------- directed vector table ----------------
    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      #1 check(vecs[i].name, bus.ReadData, vecs[i].exp_rd);
    end

    // ---------------- read gating without a clock edge ----------------
    @(negedge Clk);
    drive(32'd8, 32'h0, 1'b0, 1'b0);
    #1 check("gate_off_a8", bus.ReadData, 32'h0);
    bus.MemRead = 1'b1;
    #1 check("gate_on_a8", bus.ReadData, 32'h7);
    bus.Address = 32'd64;
    #1 check("addr_follow_w16", bus.ReadData, 32'h5555_5555);

    // ---------------- asynchronous reset mid-run ----------------
    @(negedge Clk);
    drive(32'd0, 32'h0, 1'b0, 1'b1);
    #1 check("pre_async_a0", bus.ReadData, 32'hDEAD_BEEF);
    #1 Rst = 1'b0;
    #1 check("async_rst_now", bus.ReadData, 32'h0);
    @(negedge Clk);
    #2 Rst = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        @(negedge Clk);
        drive(vecs[i].addr, 32'h0, 1'b0, 1'b1);
        #1 check("after_async_rst", bus.ReadData, 32'h0);
      end
    end

    // ---------------- random traffic vs word-array model ----------------
    for (int k = 0; k < 1024; k++) mdl[k] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic        r;
      logic [31:0] exp;
      // Mostly a small window so reads hit written words; sometimes full range.
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      d = $urandom();
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      @(negedge Clk);
      drive(a, d, w, r);
      exp = r ? mdl[widx(a)] : 32'h0;
      #1 check("random", bus.ReadData, exp);
      if (w) mdl[widx(a)] = d;
    end

    @(negedge Clk);
    drive(32'd0, 32'h0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_data_memory
`default_nettype wire
